// File: rtl/execute_pkg.sv
// Shared definitions for the execute stage.
//   op_t   : 4-bit operation code carried on in_op.
//   RSEL0_*: port-0 register select encodings (Rx, Ry, LR, ILR).
//   RSEL1_*: port-1 register select encodings (Rz, Ry).
package execute_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_MUL  = 4'd7,
        OP_BEQ  = 4'd8,
        OP_BNE  = 4'd9,
        OP_JMP  = 4'd10,
        OP_PUSH = 4'd11,
        OP_POP  = 4'd12,
        OP_LD   = 4'd13,
        OP_ST   = 4'd14
    } op_t;

    localparam logic [1:0] RSEL0_RX  = 2'b00;
    localparam logic [1:0] RSEL0_RY  = 2'b01;
    localparam logic [1:0] RSEL0_LR  = 2'b10;
    localparam logic [1:0] RSEL0_ILR = 2'b11;

    localparam logic RSEL1_RZ = 1'b0;
    localparam logic RSEL1_RY = 1'b1;

endpackage

// File: rtl/iter_mult.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
//   clk, rst_n : clock, asynchronous active-low reset.
//   start_i    : load operands and begin (sampled in IDLE only).
//   abort_i    : drop any multiply in progress, back to IDLE.
//   a_i, b_i   : multiplicand, multiplier.
//   busy_o     : high for exactly XLEN cycles while running.
//   done_o     : high in the last RUN cycle; result_o is valid then.
//   result_o   : low XLEN bits of a_i * b_i.
module iter_mult #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic [0:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] acc_sum;

    // The final partial product is folded in combinationally so the result
    // is available in the last RUN cycle rather than one cycle later.
    assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign busy_o   = (state_q == ST_RUN);
    assign done_o   = (state_q == ST_RUN) && (cnt_q == LAST) && !abort_i;
    assign result_o = acc_sum;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_RUN;
                    cnt_d    = '0;
                    mcand_d  = a_i;
                    mplier_d = b_i;
                    acc_d    = '0;
                end
            end
            default: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = ST_IDLE;
            end
        endcase
        if (abort_i) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/execute_pipe.sv
// Execute stage: ALU, iterative multiply, branch resolution, stack and
// load/store address generation, with a single registered output slot.
//   clk, rst_n                 : clock, asynchronous active-low reset.
//   in_valid/in_ready          : issue handshake; in_inst/pc/op/rsel/imm.
//   rf_raddr0/1, rf_rdata0/1   : register file read (same-cycle data).
//   flush                      : kill output slot, abort multiply.
//   out_valid/out_ready        : result handshake with out_result,
//                                out_store_data, out_memwr/memrd, wb.
//   br_taken/br_target         : one-cycle redirect pulse.
//   sp_out, busy               : current stack pointer, multiply running.
module execute_pipe
    import execute_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     RA_W     = 5,
    parameter int unsigned     LR_IDX   = 30,
    parameter int unsigned     ILR_IDX  = 31,
    parameter logic [XLEN-1:0] SP_RESET = 32'h0000_FFFC,
    parameter int unsigned     SP_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [3:0]      in_op,
    input  logic [1:0]      in_rsel0,
    input  logic            in_rsel1,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    output logic [RA_W-1:0] rf_raddr0,
    output logic [RA_W-1:0] rf_raddr1,
    input  logic [XLEN-1:0] rf_rdata0,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic            out_memwr,
    output logic            out_memrd,
    output logic            out_wb_en,
    output logic [RA_W-1:0] out_wb_addr,
    output logic            br_taken,
    output logic [XLEN-1:0] br_target,
    output logic [XLEN-1:0] sp_out,
    output logic            busy
);

    localparam int unsigned SHW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [XLEN-1:0] STEP = XLEN'(SP_STEP);

    op_t             op;
    logic [RA_W-1:0] rx, ry, rz;
    logic [XLEN-1:0] a, b;
    logic [SHW-1:0]  shamt;
    logic            accept;
    logic            unused_inst_bits;

    logic            mul_busy, mul_done;
    logic [XLEN-1:0] mul_result;

    logic            iss_valid, iss_memwr, iss_memrd, iss_wb_en, iss_br;
    logic [XLEN-1:0] iss_result, iss_store;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_result_q, out_result_d;
    logic [XLEN-1:0] out_store_q, out_store_d;
    logic            out_memwr_q, out_memwr_d;
    logic            out_memrd_q, out_memrd_d;
    logic            out_wb_en_q, out_wb_en_d;
    logic [RA_W-1:0] out_wb_addr_q, out_wb_addr_d;
    logic            br_taken_q, br_taken_d;
    logic [XLEN-1:0] br_target_q, br_target_d;
    logic [XLEN-1:0] sp_q, sp_d;
    logic [RA_W-1:0] mul_wb_q, mul_wb_d;

    assign op    = op_t'(in_op);
    assign rx    = RA_W'(in_inst[26:22]);
    assign ry    = RA_W'(in_inst[21:17]);
    assign rz    = RA_W'(in_inst[16:12]);
    assign a     = rf_rdata0;
    assign b     = in_use_imm ? in_imm : rf_rdata1;
    assign shamt = b[SHW-1:0];
    assign unused_inst_bits = ^{in_inst[31:27], in_inst[11:0]};

    assign busy     = mul_busy;
    assign in_ready = !mul_busy && (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        case (in_rsel0)
            RSEL0_RX: rf_raddr0 = rx;
            RSEL0_RY: rf_raddr0 = ry;
            RSEL0_LR: rf_raddr0 = RA_W'(LR_IDX);
            default:  rf_raddr0 = RA_W'(ILR_IDX);
        endcase
        rf_raddr1 = (in_rsel1 == RSEL1_RY) ? ry : rz;
    end

    iter_mult #(.XLEN(XLEN)) u_mult (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (accept && (op == OP_MUL)),
        .abort_i  (flush),
        .a_i      (a),
        .b_i      (b),
        .busy_o   (mul_busy),
        .done_o   (mul_done),
        .result_o (mul_result)
    );

    // What an accepted instruction would place in the output slot.
    always_comb begin
        iss_valid  = 1'b0;
        iss_result = '0;
        iss_store  = '0;
        iss_memwr  = 1'b0;
        iss_memrd  = 1'b0;
        iss_wb_en  = 1'b0;
        iss_br     = 1'b0;
        case (op)
            OP_ADD:  begin iss_valid = 1'b1; iss_wb_en = 1'b1; iss_result = a + b;       end
            OP_SUB:  begin iss_valid = 1'b1; iss_wb_en = 1'b1; iss_result = a - b;       end
            OP_AND:  begin iss_valid = 1'b1; iss_wb_en = 1'b1; iss_result = a & b;       end
            OP_OR:   begin iss_valid = 1'b1; iss_wb_en = 1'b1; iss_result = a | b;       end
            OP_XOR:  begin iss_valid = 1'b1; iss_wb_en = 1'b1; iss_result = a ^ b;       end
            OP_SLL:  begin iss_valid = 1'b1; iss_wb_en = 1'b1; iss_result = a << shamt;  end
            OP_SRL:  begin iss_valid = 1'b1; iss_wb_en = 1'b1; iss_result = a >> shamt;  end
            OP_BEQ:  iss_br = (a == rf_rdata1);
            OP_BNE:  iss_br = (a != rf_rdata1);
            OP_JMP:  iss_br = 1'b1;
            OP_PUSH: begin
                iss_valid  = 1'b1;
                iss_result = sp_q - STEP;
                iss_store  = a;
                iss_memwr  = 1'b1;
            end
            OP_POP:  begin
                iss_valid  = 1'b1;
                iss_result = sp_q;
                iss_memrd  = 1'b1;
                iss_wb_en  = 1'b1;
            end
            OP_LD:   begin
                iss_valid  = 1'b1;
                iss_result = a + in_imm;
                iss_memrd  = 1'b1;
                iss_wb_en  = 1'b1;
            end
            OP_ST:   begin
                iss_valid  = 1'b1;
                iss_result = a + in_imm;
                iss_store  = rf_rdata1;
                iss_memwr  = 1'b1;
            end
            default: ;  // MUL completes via the multiplier; unknown ops are NOPs
        endcase
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_store_d   = out_store_q;
        out_memwr_d   = out_memwr_q;
        out_memrd_d   = out_memrd_q;
        out_wb_en_d   = out_wb_en_q;
        out_wb_addr_d = out_wb_addr_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (mul_done) begin
            // No accept can occur while the multiplier runs, so the slot is free.
            out_valid_d   = 1'b1;
            out_result_d  = mul_result;
            out_store_d   = '0;
            out_memwr_d   = 1'b0;
            out_memrd_d   = 1'b0;
            out_wb_en_d   = 1'b1;
            out_wb_addr_d = mul_wb_q;
        end else if (accept) begin
            out_valid_d   = iss_valid;
            out_result_d  = iss_result;
            out_store_d   = iss_store;
            out_memwr_d   = iss_memwr;
            out_memrd_d   = iss_memrd;
            out_wb_en_d   = iss_wb_en;
            out_wb_addr_d = rx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        br_taken_d  = accept && iss_br;
        br_target_d = (accept && iss_br) ? (in_pc + in_imm) : br_target_q;
        mul_wb_d    = (accept && (op == OP_MUL)) ? rx : mul_wb_q;

        sp_d = sp_q;
        if (accept && (op == OP_PUSH)) sp_d = sp_q - STEP;
        if (accept && (op == OP_POP))  sp_d = sp_q + STEP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_store_q   <= '0;
            out_memwr_q   <= 1'b0;
            out_memrd_q   <= 1'b0;
            out_wb_en_q   <= 1'b0;
            out_wb_addr_q <= '0;
            br_taken_q    <= 1'b0;
            br_target_q   <= '0;
            sp_q          <= SP_RESET;
            mul_wb_q      <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_store_q   <= out_store_d;
            out_memwr_q   <= out_memwr_d;
            out_memrd_q   <= out_memrd_d;
            out_wb_en_q   <= out_wb_en_d;
            out_wb_addr_q <= out_wb_addr_d;
            br_taken_q    <= br_taken_d;
            br_target_q   <= br_target_d;
            sp_q          <= sp_d;
            mul_wb_q      <= mul_wb_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_result     = out_result_q;
    assign out_store_data = out_store_q;
    assign out_memwr      = out_memwr_q;
    assign out_memrd      = out_memrd_q;
    assign out_wb_en      = out_wb_en_q;
    assign out_wb_addr    = out_wb_addr_q;
    assign br_taken       = br_taken_q;
    assign br_target      = br_target_q;
    assign sp_out         = sp_q;

endmodule

// File: doc/execute_pipe.md
EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath, PC and SP width.
REQ-002 SHALL have parameter RA_W, default 5: register address width; instruction fields are zero-extended to RA_W.
REQ-003 SHALL have parameter LR_IDX, default 30, and ILR_IDX, default 31: link and interrupt-link register indices.
REQ-004 SHALL have parameter SP_RESET, default 32'h0000_FFFC, and SP_STEP, default 4: stack pointer reset value and push/pop step.
REQ-005 SHALL have one clock; reset is asynchronous and active-low:
  - clk  in  1  rising-edge clock.
  - rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have these input-side ports:
  - in_valid  in  1  issue request.
  - in_ready  out  1  issue accepted when in_valid && in_ready.
  - in_inst  in  32  instruction word.
  - in_pc  in  XLEN  instruction PC.
  - in_op  in  4  op_t operation.
  - in_rsel0  in  2  port-0 register select.
  - in_rsel1  in  1  port-1 register select.
  - in_imm  in  XLEN  extended immediate.
  - in_use_imm  in  1  operand B = in_imm.
REQ-007 SHALL have these register-file and flush ports:
  - rf_raddr0/rf_raddr1  out  RA_W  read addresses.
  - rf_rdata0/rf_rdata1  in  XLEN  same-cycle read data.
  - flush  in  1  pipeline kill.
REQ-008 SHALL have these output-side ports:
  - out_valid  out  1  result valid.
  - out_ready  in  1  downstream accept.
  - out_result  out  XLEN  ALU result or memory address.
  - out_store_data  out  XLEN  store data.
  - out_memwr/out_memrd  out  1  memory write/read.
  - out_wb_en  out  1  writeback enable.
  - out_wb_addr  out  RA_W  writeback register.
  - br_taken  out  1  one-cycle redirect pulse.
  - br_target  out  XLEN  redirect PC.
  - sp_out  out  XLEN  current SP.
  - busy  out  1  multiply in progress.

Function
REQ-009 SHALL drive rf_raddr0 by in_rsel0: 00 inst[26:22] (Rx), 01 inst[21:17] (Ry), 10 LR_IDX, 11 ILR_IDX.
REQ-010 SHALL drive rf_raddr1 by in_rsel1: 1 inst[21:17] (Ry), 0 inst[16:12] (Rz).
REQ-011 SHALL compute in_ready = !busy && (!out_valid || out_ready) && !flush.
REQ-012 SHALL give ADD, SUB, AND, OR, XOR, SLL and SRL the result A op B, with A = rf_rdata0, B = in_use_imm ? in_imm : rf_rdata1, shifts by B[log2(XLEN)-1:0], and arithmetic modulo 2^XLEN.
REQ-013 SHALL register single-cycle results, with out_valid rising the cycle after accept, out_wb_en=1 and out_wb_addr=inst[26:22].
REQ-014 SHALL hold every out_* signal stable while out_valid && !out_ready.
REQ-015 SHALL implement MUL as a shift-add FSM IDLE->RUN->IDLE; RUN lasts XLEN cycles with busy=1; out_valid asserts on the cycle after RUN ends; the result is the low XLEN bits of the product.
REQ-016 SHALL resolve BEQ (A==rf_rdata1), BNE (A!=rf_rdata1) and JMP (always) on accept, pulsing br_taken for exactly one cycle after accept when taken, with br_target=in_pc+in_imm.
REQ-017 SHALL produce no out_valid for branch ops.
REQ-018 SHALL implement PUSH as SP <= SP-SP_STEP at the accept edge, with out_result=SP-SP_STEP, out_store_data=A, out_memwr=1 and out_wb_en=0.
REQ-019 SHALL implement POP as out_result=SP (pre-update) with out_memrd=1, out_wb_en=1 and out_wb_addr=inst[26:22], and SP <= SP+SP_STEP at the accept edge.
REQ-020 SHALL wrap SP modulo 2^XLEN with no fault.
REQ-021 SHALL implement LD/ST as address=A+in_imm with out_memrd/out_memwr=1, and ST with out_store_data=rf_rdata1.
REQ-022 SHALL, on flush, clear out_valid, abort RUN to IDLE, suppress br_taken and block acceptance that cycle.
REQ-023 SHALL keep SP updates from earlier accepts on flush, and SHALL not change SP when flush and in_valid coincide.
REQ-024 SHALL treat an unknown op as a NOP: accepted, with no output, no SP change and no branch.

Reset
REQ-025 SHALL, while rst_n=0, force out_valid=0, br_taken=0, busy=0, FSM=IDLE, sp_out=SP_RESET, and all data outputs to 0.
REQ-026 SHALL, on reset assertion mid-MUL, abandon the multiply immediately, with no output after release.

Structure
REQ-027 SHALL place op_t (4-bit enum: ADD, SUB, AND, OR, XOR, SLL, SRL, MUL, BEQ, BNE, JMP, PUSH, POP, LD, ST) and the rsel encodings in the shared package execute_pkg.
REQ-028 SHALL contain one sub-module, iter_mult, holding the XLEN-cycle shift-add multiplier with start/done handshake.

Verification
REQ-029 SHALL cover ADD: A=5, B=7, out_ready=1 -> out_valid next cycle, out_result=12, out_wb_en=1.
REQ-030 SHALL cover MUL: 3 x 0xFFFF_FFFF -> busy high 32 cycles, then out_result=0xFFFF_FFFD, and in_ready=0 throughout.
REQ-031 SHALL cover PUSH after reset -> out_result=0x0000_FFF8, out_memwr=1, sp_out=0x0000_FFF8; a following POP -> out_result=0x0000_FFF8, sp_out=0x0000_FFFC.
REQ-032 SHALL cover BEQ with equal operands, pc=0x100, imm=0x20 -> br_taken pulse of one cycle, br_target=0x120, out_valid stays 0.
REQ-033 SHALL cover backpressure, out_ready=0 for 3 cycles -> outputs stable and in_ready=0; flush in cycle 10 of a MUL -> busy=0 next cycle, no out_valid.
REQ-034 SHALL cover SP=0 with POP pending -> SP wraps correctly; PUSH at SP=0 -> sp_out=0xFFFF_FFFC.
